// File: rtl/ipif_regs_be.sv
// ipif_regs_be
//
// IPIF slave register file for NetFPGA-10G pcores. Software-written
// registers (WO, then RW) and hardware-supplied read-only registers (RO)
// share one chip-select and are laid out in word-index order WO, RW, RO.
// Writes merge byte by byte under Bus2IP_BE. A three-state handshake
// (IDLE, ACK, HOLD) gives exactly one acknowledge per access, however long
// Bus2IP_CS stays high. Per-register strobes, aligned with the acknowledge,
// let user logic build write-triggered commands and clear-on-read counters.
//
// Optional feature: define IPIF_REGS_BE_ADDR_ERR_EN to flag out-of-range
// accesses and writes to RO indices on IP2Bus_Error. When it is undefined,
// IP2Bus_Error is constant 0.
//
// Ports:
//   Bus2IP_Clk, Bus2IP_Reset   clock, asynchronous active-high reset
//   Bus2IP_Addr/CS/RNW/Data/BE IPIF request (byte address, select, dir, data)
//   IP2Bus_Data/RdAck/WrAck    registered read data and one-cycle acks
//   IP2Bus_Error               qualifies the ack
//   wo_regs, rw_regs           packed software registers, register 0 in LSBs
//   ro_regs                    packed hardware values, sampled on read
//   wr_strobe, rd_strobe       one-cycle per-register access pulses
// A port whose register count is 0 is one bit wide and tied to 0.
module ipif_regs_be #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int NUM_WO_REGS        = 1,
    parameter int NUM_RW_REGS        = 8,
    parameter int NUM_RO_REGS        = 10,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] RW_RESET_VAL = '0,
    localparam int WO_W = (NUM_WO_REGS > 0) ? NUM_WO_REGS * C_S_AXI_DATA_WIDTH : 1,
    localparam int RW_W = (NUM_RW_REGS > 0) ? NUM_RW_REGS * C_S_AXI_DATA_WIDTH : 1,
    localparam int RO_W = (NUM_RO_REGS > 0) ? NUM_RO_REGS * C_S_AXI_DATA_WIDTH : 1,
    localparam int WS_W = (NUM_WO_REGS + NUM_RW_REGS > 0) ? NUM_WO_REGS + NUM_RW_REGS : 1,
    localparam int RS_W = (NUM_RO_REGS > 0) ? NUM_RO_REGS : 1
) (
    input  logic                            Bus2IP_Clk,
    input  logic                            Bus2IP_Reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   Bus2IP_Addr,
    input  logic                            Bus2IP_CS,
    input  logic                            Bus2IP_RNW,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   Bus2IP_Data,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] Bus2IP_BE,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   IP2Bus_Data,
    output logic                            IP2Bus_RdAck,
    output logic                            IP2Bus_WrAck,
    output logic                            IP2Bus_Error,
    output logic [WO_W-1:0]                 wo_regs,
    output logic [RW_W-1:0]                 rw_regs,
    input  logic [RO_W-1:0]                 ro_regs,
    output logic [WS_W-1:0]                 wr_strobe,
    output logic [RS_W-1:0]                 rd_strobe
);

    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int NBYTES = DW / 8;
    localparam int NW     = NUM_WO_REGS;
    localparam int NR     = NUM_RW_REGS;
    localparam int NRO    = NUM_RO_REGS;
    localparam int NSW    = NW + NR;
    localparam int TOTAL  = NSW + NRO;
    localparam int BL     = $clog2(NBYTES);
    localparam int IW     = ($clog2(TOTAL) > 1) ? $clog2(TOTAL) : 1;
    localparam int SW_A   = (NSW > 0) ? NSW : 1;
    localparam int RO_A   = (NRO > 0) ? NRO : 1;

    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

    state_t                 state;
    logic [SW_A*DW-1:0]     sw_q;
    logic [RO_A*DW-1:0]     ro_ext;
    logic [31:0]            idx_ext;
    logic [DW-1:0]          rd_value;
    logic [WS_W-1:0]        wr_hit;
    logic [RS_W-1:0]        rd_hit;
    logic                   addr_err;
    logic                   unused_bits;

    // Only the word-index bits of the address matter; the rest are
    // deliberately ignored, so registers alias through the upper bits.
    assign idx_ext     = 32'(Bus2IP_Addr[IW+BL-1:BL]);
    assign unused_bits = ^{Bus2IP_Addr, ro_regs};

    // Software registers live in one packed vector, WO first then RW, so a
    // word index below NSW addresses it directly.
    generate
        if (NW > 0) begin : g_wo
            assign wo_regs = sw_q[NW*DW-1:0];
        end else begin : g_no_wo
            assign wo_regs = '0;
        end
        if (NR > 0) begin : g_rw
            assign rw_regs = sw_q[NSW*DW-1:NW*DW];
        end else begin : g_no_rw
            assign rw_regs = '0;
        end
        if (NRO > 0) begin : g_ro
            assign ro_ext = ro_regs;
        end else begin : g_no_ro
            assign ro_ext = '0;
        end
    endgenerate

    // Address decode for the current request: read mux value, one-hot
    // register hits and the error condition. WO reads deliberately return 0.
    always_comb begin
        rd_value = '0;
        wr_hit   = '0;
        rd_hit   = '0;
        for (int i = 0; i < NSW; i++) begin
            if (idx_ext == 32'(i))
                wr_hit[i] = 1'b1;
        end
        for (int i = 0; i < NR; i++) begin
            if (idx_ext == 32'(NW + i))
                rd_value = sw_q[(NW + i) * DW +: DW];
        end
        for (int i = 0; i < NRO; i++) begin
            if (idx_ext == 32'(NSW + i)) begin
                rd_value  = ro_ext[i * DW +: DW];
                rd_hit[i] = 1'b1;
            end
        end
`ifdef IPIF_REGS_BE_ADDR_ERR_EN
        addr_err = (idx_ext >= 32'(TOTAL)) || (!Bus2IP_RNW && (idx_ext >= 32'(NSW)));
`else
        addr_err = 1'b0;
`endif
    end

    // Handshake FSM. All side effects (register writes, read capture, ack,
    // strobes) are committed on the IDLE->ACK edge only; ACK clears the
    // pulses and HOLD waits for CS to drop so a long CS cannot re-trigger.
    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            state        <= IDLE;
            IP2Bus_Data  <= '0;
            IP2Bus_RdAck <= 1'b0;
            IP2Bus_WrAck <= 1'b0;
            IP2Bus_Error <= 1'b0;
            wr_strobe    <= '0;
            rd_strobe    <= '0;
            sw_q         <= {SW_A{RW_RESET_VAL}};
        end else begin
            case (state)
                IDLE: begin
                    if (Bus2IP_CS) begin
                        state        <= ACK;
                        IP2Bus_Error <= addr_err;
                        if (Bus2IP_RNW) begin
                            IP2Bus_RdAck <= 1'b1;
                            IP2Bus_Data  <= rd_value;
                            rd_strobe    <= rd_hit;
                        end else begin
                            IP2Bus_WrAck <= 1'b1;
                            wr_strobe    <= wr_hit;
                            for (int i = 0; i < NSW; i++) begin
                                for (int k = 0; k < NBYTES; k++) begin
                                    if (wr_hit[i] && Bus2IP_BE[k])
                                        sw_q[i*DW + k*8 +: 8] <= Bus2IP_Data[k*8 +: 8];
                                end
                            end
                        end
                    end
                end
                ACK: begin
                    state        <= HOLD;
                    IP2Bus_RdAck <= 1'b0;
                    IP2Bus_WrAck <= 1'b0;
                    IP2Bus_Error <= 1'b0;
                    wr_strobe    <= '0;
                    rd_strobe    <= '0;
                end
                HOLD: begin
                    if (!Bus2IP_CS)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ipif_regs_be.sv
// tb_ipif_regs_be
//
// Self-checking bench for ipif_regs_be with 1 WO, 8 RW and 10 RO registers
// and a non-zero reset value. Directed vectors come from a table; random
// accesses are checked against a word-indexed array model of the register
// map. A negedge monitor counts acks and strobe pulses.
module tb_ipif_regs_be;

    localparam int NW    = 1;
    localparam int NR    = 8;
    localparam int NRO   = 10;
    localparam int NSW   = NW + NR;
    localparam int TOTAL = NSW + NRO;
    localparam logic [31:0] RST_VAL = 32'h5A5A_C3C3;
`ifdef IPIF_REGS_BE_ADDR_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic                 Bus2IP_Clk = 1'b0;
    logic                 Bus2IP_Reset;
    logic [31:0]          Bus2IP_Addr;
    logic                 Bus2IP_CS;
    logic                 Bus2IP_RNW;
    logic [31:0]          Bus2IP_Data;
    logic [3:0]           Bus2IP_BE;
    logic [31:0]          IP2Bus_Data;
    logic                 IP2Bus_RdAck;
    logic                 IP2Bus_WrAck;
    logic                 IP2Bus_Error;
    logic [NW*32-1:0]     wo_regs;
    logic [NR*32-1:0]     rw_regs;
    logic [NRO*32-1:0]    ro_regs;
    logic [NSW-1:0]       wr_strobe;
    logic [NRO-1:0]       rd_strobe;

    int checks = 0;
    int errors = 0;

    // Monitor counters
    int ackCnt = 0;
    int badStrobe = 0;
    int wrCnt [0:NSW-1];
    int rdCnt [0:NRO-1];

    // Reference model: word-indexed register contents
    logic [31:0] modelSw [0:NSW-1];
    logic [31:0] modelRo [0:NRO-1];
    logic [31:0] lastRead;

    typedef struct {
        logic        rnw;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] expData;
        logic        expErr;
    } vec_t;

    vec_t vecs [0:14];

    ipif_regs_be #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (32),
        .NUM_WO_REGS        (NW),
        .NUM_RW_REGS        (NR),
        .NUM_RO_REGS        (NRO),
        .RW_RESET_VAL       (RST_VAL)
    ) dut (
        .Bus2IP_Clk   (Bus2IP_Clk),
        .Bus2IP_Reset (Bus2IP_Reset),
        .Bus2IP_Addr  (Bus2IP_Addr),
        .Bus2IP_CS    (Bus2IP_CS),
        .Bus2IP_RNW   (Bus2IP_RNW),
        .Bus2IP_Data  (Bus2IP_Data),
        .Bus2IP_BE    (Bus2IP_BE),
        .IP2Bus_Data  (IP2Bus_Data),
        .IP2Bus_RdAck (IP2Bus_RdAck),
        .IP2Bus_WrAck (IP2Bus_WrAck),
        .IP2Bus_Error (IP2Bus_Error),
        .wo_regs      (wo_regs),
        .rw_regs      (rw_regs),
        .ro_regs      (ro_regs),
        .wr_strobe    (wr_strobe),
        .rd_strobe    (rd_strobe)
    );

    always #5 Bus2IP_Clk = ~Bus2IP_Clk;

    // Count ack pulses and strobe pulses; a strobe without its matching ack,
    // or more than one strobe bit at once, is counted as misaligned.
    always @(negedge Bus2IP_Clk) begin
        if (IP2Bus_RdAck || IP2Bus_WrAck)
            ackCnt <= ackCnt + 1;
        for (int i = 0; i < NSW; i++)
            if (wr_strobe[i]) wrCnt[i] <= wrCnt[i] + 1;
        for (int i = 0; i < NRO; i++)
            if (rd_strobe[i]) rdCnt[i] <= rdCnt[i] + 1;
        if ((wr_strobe != '0 && !IP2Bus_WrAck) || (rd_strobe != '0 && !IP2Bus_RdAck) ||
            ($countones(wr_strobe) > 1) || ($countones(rd_strobe) > 1))
            badStrobe <= badStrobe + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] modelRead(input int idx);
        if (idx < NW)         return 32'h0;
        else if (idx < NSW)   return modelSw[idx];
        else if (idx < TOTAL) return modelRo[idx - NSW];
        else                  return 32'h0;
    endfunction

    task automatic resetModel();
        for (int i = 0; i < NSW; i++) modelSw[i] = RST_VAL;
        lastRead = 32'h0;
    endtask

    task automatic setRo(input int i, input logic [31:0] val);
        modelRo[i] = val;
        ro_regs[i*32 +: 32] = val;
    endtask

    task automatic checkRegs(input string tag);
        checkOutput({tag, " wo0"}, wo_regs[31:0], modelSw[0]);
        for (int i = 0; i < NR; i++)
            checkOutput($sformatf("%s rw%0d", tag, i), rw_regs[i*32 +: 32], modelSw[NW + i]);
    endtask

    // One bus access: raise CS, wait (bounded) for the ack, then keep CS
    // high for holdCycles while scrambling address/data, then drop CS.
    task automatic applyStimulus(input logic rnw, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] be, input int holdCycles,
                                 output logic [31:0] rdata, output logic err, output int latency);
        int n;
        @(posedge Bus2IP_Clk); #1;
        Bus2IP_CS   = 1'b1;
        Bus2IP_RNW  = rnw;
        Bus2IP_Addr = addr;
        Bus2IP_Data = data;
        Bus2IP_BE   = be;
        rdata   = 32'h0;
        err     = 1'b0;
        latency = 0;
        n = 0;
        while (n < 20) begin
            @(negedge Bus2IP_Clk);
            n++;
            if (IP2Bus_RdAck || IP2Bus_WrAck) begin
                rdata   = IP2Bus_Data;
                err     = IP2Bus_Error;
                latency = n;
                break;
            end
        end
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge Bus2IP_Clk); #1;
            Bus2IP_Addr = addr ^ 32'h0000_0004;
            Bus2IP_Data = ~data;
            Bus2IP_RNW  = ~rnw;
        end
        @(posedge Bus2IP_Clk); #1;
        Bus2IP_CS = 1'b0;
    endtask

    // Access plus all model-based checks: latency, single ack, error,
    // data, strobes and resulting register contents.
    task automatic runAccess(input logic rnw, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] be, input int holdCycles,
                             output logic [31:0] rdata, output logic err);
        int idx, lat, ackBefore, badBefore, wrSum, rdSum;
        int wrBefore [0:NSW-1];
        int rdBefore [0:NRO-1];
        logic [31:0] expRd;
        logic expErr, isSwWrite, isRoRead;
        idx       = int'((addr >> 2) & 32'h1F);
        expRd     = modelRead(idx);
        expErr    = ERR_ON && ((idx >= TOTAL) || (!rnw && idx >= NSW));
        isSwWrite = !rnw && (idx < NSW);
        isRoRead  = rnw && (idx >= NSW) && (idx < TOTAL);
        ackBefore = ackCnt;
        badBefore = badStrobe;
        wrBefore  = wrCnt;
        rdBefore  = rdCnt;
        applyStimulus(rnw, addr, data, be, holdCycles, rdata, err, lat);
        if (isSwWrite)
            for (int k = 0; k < 4; k++)
                if (be[k]) modelSw[idx][k*8 +: 8] = data[k*8 +: 8];
        if (rnw) lastRead = expRd;
        checkOutput("ack latency", 32'(lat), 32'd2);
        checkOutput("ack count", 32'(ackCnt - ackBefore), 32'd1);
        checkOutput("error flag", 32'(err), 32'(expErr));
        if (rnw) checkOutput("read data", rdata, expRd);
        else     checkOutput("data hold", IP2Bus_Data, lastRead);
        wrSum = 0;
        rdSum = 0;
        for (int i = 0; i < NSW; i++) wrSum += wrCnt[i] - wrBefore[i];
        for (int i = 0; i < NRO; i++) rdSum += rdCnt[i] - rdBefore[i];
        checkOutput("wr strobe total", 32'(wrSum), isSwWrite ? 32'd1 : 32'd0);
        checkOutput("rd strobe total", 32'(rdSum), isRoRead ? 32'd1 : 32'd0);
        if (isSwWrite) checkOutput("wr strobe bit", 32'(wrCnt[idx] - wrBefore[idx]), 32'd1);
        if (isRoRead)  checkOutput("rd strobe bit", 32'(rdCnt[idx-NSW] - rdBefore[idx-NSW]), 32'd1);
        checkOutput("misaligned strobe", 32'(badStrobe - badBefore), 32'd0);
        checkRegs("post-access");
    endtask

    initial begin
        logic [31:0] rdata;
        logic err;
        int ackBefore;

        Bus2IP_Reset = 1'b1;
        Bus2IP_CS    = 1'b0;
        Bus2IP_RNW   = 1'b0;
        Bus2IP_Addr  = '0;
        Bus2IP_Data  = '0;
        Bus2IP_BE    = '0;
        ro_regs      = '0;
        for (int i = 0; i < NRO; i++) setRo(i, 32'hC0DE_0000 + 32'(i));
        setRo(3, 32'h1234_5678);
        resetModel();

        // Reset state
        repeat (3) @(posedge Bus2IP_Clk);
        #1;
        checkOutput("reset rdack", 32'(IP2Bus_RdAck), 32'd0);
        checkOutput("reset wrack", 32'(IP2Bus_WrAck), 32'd0);
        checkOutput("reset error", 32'(IP2Bus_Error), 32'd0);
        checkOutput("reset data", IP2Bus_Data, 32'h0);
        checkOutput("reset wr_strobe", 32'(wr_strobe), 32'd0);
        checkOutput("reset rd_strobe", 32'(rd_strobe), 32'd0);
        checkRegs("reset");
        Bus2IP_Reset = 1'b0;

        for (int i = 0; i < NR; i++) begin
            runAccess(1'b1, 32'((NW + i) * 4), 32'h0, 4'h0, 0, rdata, err);
            checkOutput($sformatf("rw%0d reset read", i), rdata, RST_VAL);
        end

        // Directed vectors
        vecs[0]  = '{1'b1, 32'h00, 32'h0,         4'h0, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'h04, 32'hDEADBEEF,  4'hF, 32'h0,         1'b0};
        vecs[2]  = '{1'b1, 32'h04, 32'h0,         4'h0, 32'hDEADBEEF,  1'b0};
        vecs[3]  = '{1'b0, 32'h04, 32'h00001100,  4'h2, 32'h0,         1'b0};
        vecs[4]  = '{1'b1, 32'h04, 32'h0,         4'h0, 32'hDEAD11EF,  1'b0};
        vecs[5]  = '{1'b1, 32'h30, 32'h0,         4'h0, 32'h12345678,  1'b0};
        vecs[6]  = '{1'b0, 32'h4C, 32'hFFFFFFFF,  4'hF, 32'h0,         ERR_ON};
        vecs[7]  = '{1'b1, 32'h4C, 32'h0,         4'h0, 32'h0,         ERR_ON};
        vecs[8]  = '{1'b0, 32'h24, 32'hAAAAAAAA,  4'hF, 32'h0,         ERR_ON};
        vecs[9]  = '{1'b1, 32'h84, 32'h0,         4'h0, 32'hDEAD11EF,  1'b0};
        vecs[10] = '{1'b0, 32'h00, 32'h01020304,  4'h5, 32'h0,         1'b0};
        vecs[11] = '{1'b1, 32'h00, 32'h0,         4'h0, 32'h0,         1'b0};
        vecs[12] = '{1'b0, 32'h20, 32'h0,         4'h0, 32'h0,         1'b0};
        vecs[13] = '{1'b1, 32'h20, 32'h0,         4'h0, RST_VAL,       1'b0};
        vecs[14] = '{1'b1, 32'h48, 32'h0,         4'h0, 32'hC0DE0009,  1'b0};

        for (int i = 0; i <= 14; i++) begin
            runAccess(vecs[i].rnw, vecs[i].addr, vecs[i].data, vecs[i].be, 0, rdata, err);
            checkOutput($sformatf("vec%0d error", i), 32'(err), 32'(vecs[i].expErr));
            if (vecs[i].rnw)
                checkOutput($sformatf("vec%0d rdata", i), rdata, vecs[i].expData);
        end
        checkOutput("wo0 byte merge", wo_regs[31:0], 32'h5A02C304);
        checkOutput("rw0 byte merge", rw_regs[31:0], 32'hDEAD11EF);

        // Long CS hold: one ack only, later address/data changes ignored
        runAccess(1'b0, 32'h08, 32'h11223344, 4'hF, 10, rdata, err);
        checkOutput("hold rw1", rw_regs[63:32], 32'h11223344);
        checkOutput("hold rw2", rw_regs[95:64], RST_VAL);

        // Reset asserted while in ACK: ack dropped, registers restored
        ackBefore = ackCnt;
        @(posedge Bus2IP_Clk); #1;
        Bus2IP_CS   = 1'b1;
        Bus2IP_RNW  = 1'b0;
        Bus2IP_Addr = 32'h10;
        Bus2IP_Data = 32'hFFFF0000;
        Bus2IP_BE   = 4'hF;
        @(posedge Bus2IP_Clk); #1;
        Bus2IP_Reset = 1'b1;
        #1;
        checkOutput("mid-reset wrack", 32'(IP2Bus_WrAck), 32'd0);
        checkOutput("mid-reset wr_strobe", 32'(wr_strobe), 32'd0);
        checkOutput("mid-reset data", IP2Bus_Data, 32'h0);
        resetModel();
        @(negedge Bus2IP_Clk);
        Bus2IP_CS = 1'b0;
        @(posedge Bus2IP_Clk); #1;
        Bus2IP_Reset = 1'b0;
        checkOutput("mid-reset ack count", 32'(ackCnt - ackBefore), 32'd0);
        checkRegs("mid-reset");
        runAccess(1'b0, 32'h10, 32'hCAFEF00D, 4'hF, 0, rdata, err);
        runAccess(1'b1, 32'h10, 32'h0, 4'h0, 1, rdata, err);
        checkOutput("after reset rw3", rdata, 32'hCAFEF00D);

        // Randomised accesses against the model
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0)
                setRo(int'($urandom_range(0, NRO - 1)), $urandom);
            runAccess(1'($urandom_range(0, 1)), $urandom, $urandom,
                      4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), rdata, err);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ipif_regs_be.md
# ipif_regs_be

Parametrised IPIF slave register file for NetFPGA-10G pcores: software-written (WO, RW) and hardware-written (RO) 32-bit-or-wider registers behind one IPIF chip-select. Writes honour byte enables. A handshake state machine issues exactly one acknowledge per access, however long Bus2IP_CS is held. Per-register write and read strobes let user logic build write-triggered commands and clear-on-read counters. Sits between the AXI-Lite-to-IPIF bridge and the pcore datapath.

## Interface
- C_S_AXI_DATA_WIDTH, 32, register and bus data width; a multiple of 8.
- C_S_AXI_ADDR_WIDTH, 32, bus address width.
- NUM_WO_REGS, 1, write-only registers; may be 0.
- NUM_RW_REGS, 8, read/write registers; may be 0.
- NUM_RO_REGS, 10, read-only registers; may be 0. The sum of the three counts is at least 1.
- RW_RESET_VAL, 0, reset value of every WO and RW register; C_S_AXI_DATA_WIDTH bits.

Ports:
- Bus2IP_Clk  in  1  the block's only clock.
- Bus2IP_Reset  in  1  reset; asynchronous, active-high.
- Bus2IP_Addr  in  C_S_AXI_ADDR_WIDTH  byte address.
- Bus2IP_CS  in  1  access request, held until acknowledged.
- Bus2IP_RNW  in  1  1 = read, 0 = write.
- Bus2IP_Data  in  C_S_AXI_DATA_WIDTH  write data.
- Bus2IP_BE  in  C_S_AXI_DATA_WIDTH/8  byte enables.
- IP2Bus_Data  out  C_S_AXI_DATA_WIDTH  read data; valid while IP2Bus_RdAck is high.
- IP2Bus_RdAck  out  1  read acknowledge, one-cycle pulse.
- IP2Bus_WrAck  out  1  write acknowledge, one-cycle pulse.
- IP2Bus_Error  out  1  error flag, qualifies an acknowledge.
- wo_regs  out  NUM_WO_REGS*C_S_AXI_DATA_WIDTH  packed WO registers; register 0 in the LSBs.
- rw_regs  out  NUM_RW_REGS*C_S_AXI_DATA_WIDTH  packed RW registers.
- ro_regs  in  NUM_RO_REGS*C_S_AXI_DATA_WIDTH  packed RO values from hardware.
- wr_strobe  out  NUM_WO_REGS+NUM_RW_REGS  one-cycle pulse per written register, WO first.
- rd_strobe  out  NUM_RO_REGS  one-cycle pulse per read RO register.

A port whose count is 0 is sized to one bit and tied to 0.

## Operation
- Word index = Bus2IP_Addr[IW+BL-1 : BL].
  - BL = log2(C_S_AXI_DATA_WIDTH/8).
  - IW = max(1, ceil(log2(total registers))).
  - Address bits above the index are ignored.
- Address map in word-index order: WO at [0, NW), RW at [NW, NW+NR), RO at [NW+NR, total). NW = NUM_WO_REGS, NR = NUM_RW_REGS.
- Write to a WO/RW index:
  - For each byte k, register byte k takes Bus2IP_Data byte k only when Bus2IP_BE[k]=1; other bytes keep their value.
  - The matching wr_strobe bit pulses, even if BE = 0.
- Write to an RO index or an out-of-range index: no register changes, WrAck is still issued.
- Read from an RW index returns the register contents. Read from an RO index returns the matching ro_regs slice and pulses the matching rd_strobe bit.
- Read from a WO index returns 0. Read from an out-of-range index returns 0.
- FSM states: IDLE, ACK, HOLD.
  - IDLE, Bus2IP_CS=1: decode, perform the write or capture the read data. Go to ACK.
  - ACK: RdAck or WrAck high for this cycle only, together with the strobe. Go to HOLD.
  - HOLD: stay while Bus2IP_CS=1. Go to IDLE when Bus2IP_CS=0.
- Register writes and read-data capture happen only on the IDLE to ACK transition.
- Bus2IP_RNW and Bus2IP_Addr are sampled in that IDLE cycle. Changes after that cycle are ignored.
- Reset, async or mid-transaction:
  - FSM returns to IDLE.
  - Acks, Error and strobes go to 0.
  - IP2Bus_Data goes to 0.
  - WO and RW registers go to RW_RESET_VAL.
  - A transaction in flight is dropped without an acknowledge.

## Timing
- Decode in IDLE at cycle N; acknowledge and strobe at N+1. The strobe is aligned with the ack.
- A register written in cycle N shows its new value on wo_regs/rw_regs at N+1.
- ro_regs is sampled at the rising edge that ends cycle N. IP2Bus_Data holds that value from N+1 until the next read capture.
- Minimum spacing between accesses is 3 cycles: IDLE, ACK, HOLD with CS low.
- A single access produces exactly one ack, even if CS is held for many cycles.
- All outputs are registered, with no combinational path from input to output.

## Configuration
- IPIF_REGS_BE_ADDR_ERR_EN defined: an out-of-range read or write, or a write to an RO index, sets IP2Bus_Error=1 in the ack cycle. Reads of WO indices still give Error=0.
- IPIF_REGS_BE_ADDR_ERR_EN undefined: IP2Bus_Error is constant 0. Behaviour is otherwise identical.

## Test plan
- Reset, then read every RW index -> RW_RESET_VAL with RdAck at N+1; read a WO index -> 0, Error=0.
- Write 0xDEADBEEF with BE=0xF to RW0, then 0x00001100 with BE=0x2 to RW0; read RW0 -> 0xDEADBEEF then 0xDEAD11EF. wr_strobe[NW] pulses twice, aligned with WrAck.
- ro_regs slice 3 = 0x12345678, read RO3 -> 0x12345678. rd_strobe[3] pulses once with RdAck, and no other strobe bit pulses.
- Hold CS high for 10 cycles on a write -> exactly one WrAck and one strobe. The next access is acknowledged only after CS has dropped.
- Write to index = total, with the macro defined -> WrAck with Error=1 and no register change. Without the macro -> Error=0.
- Assert reset in the ACK state -> no ack is seen and registers return to RW_RESET_VAL. The next access completes normally.
